// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver with a small byte FIFO, a bus-style read port and sticky error flags.
//   reset_n         asynchronous active-low reset
//   clk             system clock
//   rx              serial line, asynchronous, idle high
//   read_req        pop request; answered one cycle later by read_data_valid
//   read_data       popped byte, 0x00 when the FIFO was empty; held between pulses
//   read_data_valid one-cycle pulse answering every read_req
//   data_available  FIFO not empty
//   framing_error   sticky, stop bit sampled low
//   overflow        sticky, byte dropped because the FIFO was full
//   clear_errors    clears both sticky flags (a same-cycle error event wins)
module uart_receiver #(
    parameter int CLKS_PER_BIT    = 868,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic       reset_n,
    input  logic       clk,
    input  logic       rx,
    input  logic       read_req,
    output logic [7:0] read_data,
    output logic       read_data_valid,
    output logic       data_available,
    output logic       framing_error,
    output logic       overflow,
    input  logic       clear_errors
);
    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam int AW    = FIFO_DEPTH_LOG2;
    localparam int DEPTH = 1 << AW;
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK_WAIT} state_t;

    state_t        state;
    logic          rx_meta, rx_sync;
    logic [CW-1:0] bit_counter;
    logic [2:0]    bit_index;
    logic [7:0]    shift_reg;
    logic [7:0]    fifo_mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count, count_next;
    logic          stop_done, push, fe_set, pop, full, wr_en, ov_set;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            bit_counter <= '0;
            bit_index   <= '0;
            shift_reg   <= '0;
        end else begin
            case (state)
                IDLE: if (!rx_sync) begin
                    state       <= START;
                    bit_counter <= '0;
                end
                START: if (bit_counter == HALF_END) begin
                    // A start bit that is gone by mid-bit is a glitch, not a frame.
                    state       <= rx_sync ? IDLE : DATA;
                    bit_counter <= '0;
                    bit_index   <= '0;
                end else bit_counter <= bit_counter + 1'b1;
                DATA: if (bit_counter == BIT_END) begin
                    shift_reg   <= {rx_sync, shift_reg[7:1]};
                    bit_counter <= '0;
                    bit_index   <= bit_index + 1'b1;
                    state       <= (bit_index == 3'd7) ? STOP : DATA;
                end else bit_counter <= bit_counter + 1'b1;
                STOP: if (bit_counter == BIT_END) begin
                    state       <= rx_sync ? IDLE : BREAK_WAIT;
                    bit_counter <= '0;
                end else bit_counter <= bit_counter + 1'b1;
                // Wait out a held-low line so a break cannot look like a new start bit.
                BREAK_WAIT: if (rx_sync) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign stop_done = (state == STOP) && (bit_counter == BIT_END);
    assign push      = stop_done && rx_sync;
    assign fe_set    = stop_done && !rx_sync;
    assign full      = count[AW];
    // The pop uses the count before this cycle's push, so a push into an empty FIFO is not seen by the same read.
    assign pop       = read_req && (count != '0);
    assign wr_en     = push && (!full || pop);
    assign ov_set    = push && full && !pop;

    always_comb count_next = count + (AW + 1)'(wr_en) - (AW + 1)'(pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) fifo_mem[i] <= '0;
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            count           <= '0;
            read_data       <= '0;
            read_data_valid <= 1'b0;
            data_available  <= 1'b0;
            framing_error   <= 1'b0;
            overflow        <= 1'b0;
        end else begin
            if (wr_en) begin
                fifo_mem[wr_ptr] <= shift_reg;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count           <= count_next;
            data_available  <= count_next != '0;
            read_data       <= pop ? fifo_mem[rd_ptr] : (read_req ? 8'h00 : read_data);
            read_data_valid <= read_req;
            framing_error   <= fe_set || (framing_error && !clear_errors);
            overflow        <= ov_set || (overflow && !clear_errors);
        end
    end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed and randomized frames/reads checked against a queue-based model of the receiver.
module tb_uart_receiver;
    localparam int CPB = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0, reset_n = 1'b0, rx = 1'b1, read_req = 1'b0, clear_errors = 1'b0;
    logic [7:0] read_data;
    logic       read_data_valid, data_available, framing_error, overflow;

    int          n_checks = 0, n_errors = 0;
    byte unsigned q[$];
    logic        m_fe = 1'b0, m_ov = 1'b0;
    logic [7:0]  last_rd = 8'h00;

    always #5 clk = ~clk;

    uart_receiver #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(2)) dut (
        .reset_n(reset_n), .clk(clk), .rx(rx), .read_req(read_req),
        .read_data(read_data), .read_data_valid(read_data_valid),
        .data_available(data_available), .framing_error(framing_error),
        .overflow(overflow), .clear_errors(clear_errors)
    );

    initial begin
        #900_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, "/data_available"}, data_available, q.size() != 0);
        check({tag, "/framing_error"}, framing_error, m_fe);
        check({tag, "/overflow"}, overflow, m_ov);
    endtask

    // One 8N1 frame, rx driven right after a rising edge; the stop bit is sampled on edge 155 of the frame.
    task automatic send_frame(input logic [7:0] b, input logic stop_ok, input int hold, input logic rd, input logic clr);
        logic [9:0] bits;
        logic [7:0] exp_rd;
        bits = {stop_ok, b, 1'b0};
        for (int c = 0; c < 10 * CPB; c++) begin
            tick();
            rx = bits[c / CPB];
            read_req = rd && (c == 154);
            clear_errors = clr && (c == 154);
            if (!rd && c == 154) check("pre_push_avail", data_available, q.size() != 0);
            if (!rd && c == 155) check("push_edge_avail", data_available, (q.size() != 0) || stop_ok);
            if (rd && c == 155) begin
                exp_rd = (q.size() != 0) ? q.pop_front() : 8'h00;
                check("stop_rd_valid", read_data_valid, 1);
                check("stop_rd_data", read_data, exp_rd);
                last_rd = exp_rd;
            end
        end
        if (clr) begin
            m_fe = 1'b0;
            m_ov = 1'b0;
        end
        if (!stop_ok) m_fe = 1'b1;
        else if (q.size() < DEPTH) q.push_back(b);
        else m_ov = 1'b1;
        if (!stop_ok) repeat (hold) tick();
        rx = 1'b1;
        repeat (4) tick();
        check_state("frame");
    endtask

    task automatic do_reads(input int n);
        logic [7:0] exp_rd;
        read_req = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            if (i == n - 1) read_req = 1'b0;
            exp_rd = (q.size() != 0) ? q.pop_front() : 8'h00;
            check("rd_valid", read_data_valid, 1);
            check("rd_data", read_data, exp_rd);
            last_rd = exp_rd;
        end
        tick();
        check("rd_valid_drop", read_data_valid, 0);
        check("rd_data_hold", read_data, last_rd);
        check_state("after_rd");
    endtask

    task automatic clear();
        clear_errors = 1'b1;
        tick();
        clear_errors = 1'b0;
        m_fe = 1'b0;
        m_ov = 1'b0;
        tick();
        check_state("clear");
    endtask

    initial begin
        logic [9:0] bits;
        repeat (3) tick();
        check("rst_read_data", read_data, 0);
        check("rst_valid", read_data_valid, 0);
        check_state("reset");
        reset_n = 1'b1;
        repeat (3) tick();

        send_frame(8'hA5, 1, 0, 0, 0);
        do_reads(1);

        rx = 1'b0;
        repeat (5) tick();
        rx = 1'b1;
        repeat (20) tick();
        check_state("glitch");

        send_frame(8'h3C, 0, 48, 0, 0);
        send_frame(8'h81, 1, 0, 0, 0);
        do_reads(2);
        clear();

        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1, 0, 0, 0);
        do_reads(5);
        clear();

        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1, 0, 0, 0);
        send_frame(8'h05, 1, 0, 1, 0);
        do_reads(4);

        send_frame(8'h11, 0, 3, 0, 1);
        for (int i = 0; i < 5; i++) send_frame(8'(8'h20 + i), 1, 0, 0, 0);
        bits = {1'b1, 8'h77, 1'b0};
        for (int c = 0; c <= 70; c++) begin
            tick();
            rx = bits[c / CPB];
        end
        reset_n = 1'b0;
        #1;
        q.delete();
        m_fe = 1'b0;
        m_ov = 1'b0;
        check("midrst_read_data", read_data, 0);
        check("midrst_valid", read_data_valid, 0);
        check_state("midrst");
        rx = 1'b1;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (3) tick();
        send_frame(8'h5A, 1, 0, 0, 0);
        do_reads(1);

        for (int k = 0; k < 40; k++) begin
            int unsigned sel;
            sel = $urandom_range(0, 99);
            if (sel < 60)
                send_frame(8'($urandom), $urandom_range(0, 99) < 85, $urandom_range(0, 40),
                           $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10);
            else if (sel < 85) do_reads($urandom_range(1, 3));
            else clear();
        end
        do_reads(q.size() + 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
